// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// HAZARD_STATS_EN adds the stall/flush statistics widths.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_e;

  localparam int unsigned MDU_LAT_DEF = 4;
  localparam int unsigned REG_W       = 5;
  localparam int unsigned CNT_W       = 4;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

`ifdef HAZARD_STATS_EN
  localparam int unsigned STALL_CNT_W = 32;
  localparam int unsigned FLUSH_CNT_W = 16;
`endif

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signals of the hazard controller: decode/execute status in, stage enables out.
// HAZARD_STATS_EN adds the stall_cnt/flush_cnt statistics outputs.
interface pipe_hazard_ctrl_if;
  import pipe_ctrl_pkg::*;

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             idex_mem_read;
  logic [REG_W-1:0] idex_dst;
  logic             mdu_start;
  logic             br_taken;
  logic             jump_id;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_write;
  logic idex_bubble;
  logic mdu_done;
  logic busy;

`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;
`endif

  modport master (
    output id_rs, id_rt, id_uses_rt, idex_mem_read, idex_dst, mdu_start, br_taken, jump_id,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mdu_done, busy
`ifdef HAZARD_STATS_EN
    , input stall_cnt, flush_cnt
`endif
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, idex_mem_read, idex_dst, mdu_start, br_taken, jump_id,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mdu_done, busy
`ifdef HAZARD_STATS_EN
    , output stall_cnt, flush_cnt
`endif
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds a source of the instruction in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic             mem_read,
  input  logic [REG_W-1:0] dst,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             uses_rt,
  output logic             load_use_c
);

  // r0 is hardwired to zero, so a load targeting it never creates a dependency
  assign load_use_c = mem_read && (dst != REG_ZERO) &&
                      ((dst == rs) || (uses_rt && (dst == rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, branch/jump flushes and multi-cycle EX stalls.
// Optional HAZARD_STATS_EN build adds saturating stall/flush cycle counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEF
)
(
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  // The start cycle and the final (wait_cnt==0) cycle account for two of the MDU_LAT stalls
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MDU_LAT - 2);

  state_e           state;
  state_e           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_nxt;
  logic             load_use;

  logic pc_write_c;
  logic ifid_write_c;
  logic ifid_flush_c;
  logic idex_write_c;
  logic idex_bubble_c;
  logic mdu_done_c;
  logic busy_c;

  hazard_detect u_hazard_detect (
    .mem_read   (bus.idex_mem_read),
    .dst        (bus.idex_dst),
    .rs         (bus.id_rs),
    .rt         (bus.id_rt),
    .uses_rt    (bus.id_uses_rt),
    .load_use_c (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next state and stage enables; reset forces the free-running defaults
  always_comb begin
    state_nxt     = state;
    wait_cnt_nxt  = wait_cnt;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    ifid_flush_c  = 1'b0;
    idex_write_c  = 1'b1;
    idex_bubble_c = 1'b0;
    mdu_done_c    = 1'b0;
    busy_c        = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (bus.mdu_start) begin
            pc_write_c   = 1'b0;
            ifid_write_c = 1'b0;
            idex_write_c = 1'b0;
            state_nxt    = MDU_WAIT;
            wait_cnt_nxt = WAIT_LOAD;
          end else if (bus.br_taken) begin
            ifid_flush_c  = 1'b1;
            idex_bubble_c = 1'b1;
          end else if (load_use) begin
            pc_write_c    = 1'b0;
            ifid_write_c  = 1'b0;
            idex_bubble_c = 1'b1;
          end else if (bus.jump_id) begin
            ifid_flush_c = 1'b1;
          end
        end
        MDU_WAIT: begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          idex_write_c = 1'b0;
          busy_c       = 1'b1;
          if (wait_cnt == '0) begin
            mdu_done_c   = 1'b1;
            state_nxt    = RUN;
            wait_cnt_nxt = '0;
          end else begin
            wait_cnt_nxt = wait_cnt - CNT_W'(1);
          end
        end
        default: begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign bus.pc_write    = pc_write_c;
  assign bus.ifid_write  = ifid_write_c;
  assign bus.ifid_flush  = ifid_flush_c;
  assign bus.idex_write  = idex_write_c;
  assign bus.idex_bubble = idex_bubble_c;
  assign bus.mdu_done    = mdu_done_c;
  assign bus.busy        = busy_c;

`ifdef HAZARD_STATS_EN
  logic [STALL_CNT_W-1:0] stall_cnt;
  logic [FLUSH_CNT_W-1:0] flush_cnt;

  // Saturating cycle counters for frozen-PC and flushed-fetch cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (!pc_write_c && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (ifid_flush_c && (flush_cnt != '1)) flush_cnt <= flush_cnt + FLUSH_CNT_W'(1);
    end
  end

  assign bus.stall_cnt = stall_cnt;
  assign bus.flush_cnt = flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic
// against a cycle-level reference model; stats checks when HAZARD_STATS_EN is defined.
module tb_pipe_hazard_ctrl;

  localparam int unsigned MDU_LAT = 4;

  // {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mdu_done, busy}
  localparam logic [6:0] O_IDLE   = 7'b1101000;
  localparam logic [6:0] O_LU     = 7'b0001100;
  localparam logic [6:0] O_BR     = 7'b1111100;
  localparam logic [6:0] O_JMP    = 7'b1111000;
  localparam logic [6:0] O_MSTART = 7'b0000000;
  localparam logic [6:0] O_MWAIT  = 7'b0000001;
  localparam logic [6:0] O_MDONE  = 7'b0000011;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  pipe_hazard_ctrl_if bus_if ();

  pipe_hazard_ctrl #(.MDU_LAT(MDU_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] outs();
    return {bus_if.pc_write, bus_if.ifid_write, bus_if.ifid_flush, bus_if.idex_write,
            bus_if.idex_bubble, bus_if.mdu_done, bus_if.busy};
  endfunction

  task automatic drive(input logic r, input logic ms, input logic br, input logic j,
                       input logic mr, input logic [4:0] dst, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt);
    rst                  = r;
    bus_if.mdu_start     = ms;
    bus_if.br_taken      = br;
    bus_if.jump_id       = j;
    bus_if.idex_mem_read = mr;
    bus_if.idex_dst      = dst;
    bus_if.id_rs         = rs;
    bus_if.id_rt         = rt;
    bus_if.id_uses_rt    = urt;
  endtask

  // Apply inputs mid-cycle (after the negedge) so outputs settle well before the next posedge
  task automatic step(input logic r, input logic ms, input logic br, input logic j,
                      input logic mr, input logic [4:0] dst, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt);
    @(negedge clk);
    drive(r, ms, br, j, mr, dst, rs, rt, urt);
    #1;
  endtask

  task automatic test_reset();
    step(1, 1, 1, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    n_cmp++;
    if (outs() !== O_IDLE) begin
      n_bad++; $display("FAIL reset_hold: got %b want %b", outs(), O_IDLE);
    end
    step(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    n_cmp++;
    if (outs() !== O_IDLE) begin
      n_bad++; $display("FAIL reset_jump_masked: got %b want %b", outs(), O_IDLE);
    end
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    n_cmp++;
    if (outs() !== O_IDLE) begin
      n_bad++; $display("FAIL reset_release_idle: got %b want %b", outs(), O_IDLE);
    end
  endtask

  task automatic test_load_use();
    step(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    n_cmp++;
    if (outs() !== O_LU) begin
      n_bad++; $display("FAIL load_use_rs: got %b want %b", outs(), O_LU);
    end
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    n_cmp++;
    if (outs() !== O_IDLE) begin
      n_bad++; $display("FAIL load_use_single_bubble: got %b want %b", outs(), O_IDLE);
    end
    step(0, 0, 0, 0, 1, 5'd8, 5'd3, 5'd8, 1);
    n_cmp++;
    if (outs() !== O_LU) begin
      n_bad++; $display("FAIL load_use_rt: got %b want %b", outs(), O_LU);
    end
    step(0, 0, 0, 0, 1, 5'd8, 5'd3, 5'd8, 0);
    n_cmp++;
    if (outs() !== O_IDLE) begin
      n_bad++; $display("FAIL load_use_rt_unused: got %b want %b", outs(), O_IDLE);
    end
    step(0, 0, 0, 0, 0, 5'd8, 5'd8, 5'd0, 0);
    n_cmp++;
    if (outs() !== O_IDLE) begin
      n_bad++; $display("FAIL load_use_not_load: got %b want %b", outs(), O_IDLE);
    end
  endtask

  task automatic test_load_use_zero();
    step(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
    n_cmp++;
    if (outs() !== O_IDLE) begin
      n_bad++; $display("FAIL load_use_r0: got %b want %b", outs(), O_IDLE);
    end
  endtask

  // Events held high during the wait must have no effect on the stall
  task automatic test_mdu();
    logic [6:0] want [5];
    want = '{O_MSTART, O_MWAIT, O_MWAIT, O_MDONE, O_IDLE};
    for (int c = 0; c < 5; c++) begin
      if (c == 0)      step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      else if (c < 4)  step(0, 1, 1, 1, 1, 5'd8, 5'd8, 5'd0, 0);
      else             step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      n_cmp++;
      if (outs() !== want[c]) begin
        n_bad++; $display("FAIL mdu_cycle%0d: got %b want %b", c + 1, outs(), want[c]);
      end
    end
  endtask

  task automatic test_priority();
    logic [6:0] want [4];
    want = '{O_MWAIT, O_MWAIT, O_MDONE, O_IDLE};
    step(0, 0, 1, 0, 1, 5'd8, 5'd8, 5'd0, 0);
    n_cmp++;
    if (outs() !== O_BR) begin
      n_bad++; $display("FAIL prio_br_over_lu: got %b want %b", outs(), O_BR);
    end
    step(0, 0, 0, 1, 1, 5'd9, 5'd1, 5'd9, 1);
    n_cmp++;
    if (outs() !== O_LU) begin
      n_bad++; $display("FAIL prio_lu_over_jump: got %b want %b", outs(), O_LU);
    end
    step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0);
    n_cmp++;
    if (outs() !== O_JMP) begin
      n_bad++; $display("FAIL jump_only: got %b want %b", outs(), O_JMP);
    end
    step(0, 1, 1, 1, 1, 5'd8, 5'd8, 5'd0, 0);
    n_cmp++;
    if (outs() !== O_MSTART) begin
      n_bad++; $display("FAIL prio_mdu_over_br: got %b want %b", outs(), O_MSTART);
    end
    for (int c = 0; c < 4; c++) begin
      step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      n_cmp++;
      if (outs() !== want[c]) begin
        n_bad++; $display("FAIL prio_mdu_tail%0d: got %b want %b", c, outs(), want[c]);
      end
    end
  endtask

  task automatic test_reset_in_mdu();
    logic [6:0] want [4];
    want = '{O_MSTART, O_MWAIT, O_IDLE, O_IDLE};
    for (int c = 0; c < 4; c++) begin
      step((c == 2) ? 1'b1 : 1'b0, (c == 0) ? 1'b1 : 1'b0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
      n_cmp++;
      if (outs() !== want[c]) begin
        n_bad++; $display("FAIL rst_in_mdu_cycle%0d: got %b want %b", c + 1, outs(), want[c]);
      end
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    n_cmp++;
    if (bus_if.stall_cnt !== 32'd0 || bus_if.flush_cnt !== 16'd0) begin
      n_bad++;
      $display("FAIL stats_clear: got %0d/%0d want 0/0", bus_if.stall_cnt, bus_if.flush_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0);
      step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    end
    for (int k = 0; k < 2; k++) step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    n_cmp++;
    if (bus_if.stall_cnt !== 32'd3 || bus_if.flush_cnt !== 16'd2) begin
      n_bad++;
      $display("FAIL stats_count: got %0d/%0d want 3/2", bus_if.stall_cnt, bus_if.flush_cnt);
    end
  endtask
`endif

  // Reference model: mdu_left is the number of MDU stall cycles still owed after the current one
  task automatic test_random();
    int          mdu_left;
    int          exp_stall;
    int          exp_flush;
    logic [6:0]  want;
    logic        r, ms, br, j, mr, urt, lu;
    logic [4:0]  dst, rs, rt;
    step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    mdu_left  = 0;
    exp_stall = 0;
    exp_flush = 0;
    for (int c = 0; c < 600; c++) begin
      r   = ($urandom_range(0, 63) == 0);
      ms  = ($urandom_range(0, 9) == 0);
      br  = ($urandom_range(0, 5) == 0);
      j   = ($urandom_range(0, 5) == 0);
      mr  = $urandom_range(0, 1) == 1;
      urt = $urandom_range(0, 1) == 1;
      dst = 5'($urandom_range(0, 3));
      rs  = 5'($urandom_range(0, 3));
      rt  = 5'($urandom_range(0, 3));
      step(r, ms, br, j, mr, dst, rs, rt, urt);
      lu = mr && (dst != 5'd0) && ((dst == rs) || (urt && (dst == rt)));
      if (r) begin
        want = O_IDLE;
        mdu_left = 0;
      end else if (mdu_left > 0) begin
        want = (mdu_left == 1) ? O_MDONE : O_MWAIT;
        mdu_left--;
      end else if (ms) begin
        want = O_MSTART;
        mdu_left = MDU_LAT - 1;
      end else if (br) begin
        want = O_BR;
      end else if (lu) begin
        want = O_LU;
      end else if (j) begin
        want = O_JMP;
      end else begin
        want = O_IDLE;
      end
      n_cmp++;
      if (outs() !== want) begin
        n_bad++;
        $display("FAIL random_cycle%0d: got %b want %b (rst=%b ms=%b br=%b j=%b lu=%b)",
                 c, outs(), want, r, ms, br, j, lu);
      end
`ifdef HAZARD_STATS_EN
      n_cmp++;
      if (bus_if.stall_cnt !== 32'(exp_stall) || bus_if.flush_cnt !== 16'(exp_flush)) begin
        n_bad++;
        $display("FAIL random_stats%0d: got %0d/%0d want %0d/%0d", c,
                 bus_if.stall_cnt, bus_if.flush_cnt, exp_stall, exp_flush);
      end
`endif
      if (r) begin
        exp_stall = 0;
        exp_flush = 0;
      end else begin
        if (!want[6]) exp_stall++;
        if (want[4])  exp_flush++;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    test_reset();
    test_load_use();
    test_load_use_zero();
    test_mdu();
    test_priority();
    test_reset_in_mdu();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MDU_LAT, default 4: total stall cycles for a multi-cycle EX op; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 id_rs  input  5  rs field of the instruction in ID.
REQ-005 id_rt  input  5  rt field of the instruction in ID.
REQ-006 id_uses_rt  input  1  ID instruction reads rt.
REQ-007 idex_mem_read  input  1  instruction in EX is a load.
REQ-008 idex_dst  input  5  selected destination register of the instruction in EX.
REQ-009 mdu_start  input  1  instruction in EX is a multi-cycle op; valid in RUN only.
REQ-010 br_taken  input  1  branch resolved taken in EX.
REQ-011 jump_id  input  1  jump decoded in ID.
REQ-012 pc_write  output  1  PC update enable.
REQ-013 ifid_write  output  1  IF/ID register load enable.
REQ-014 ifid_flush  output  1  IF/ID register cleared to NOP.
REQ-015 idex_write  output  1  ID/EX register load enable.
REQ-016 idex_bubble  output  1  zero all ID/EX control fields (RegWrite, Mem_Read, Mem_Write) on load.
REQ-017 mdu_done  output  1  one-cycle pulse on the last stalled cycle of an MDU op.
REQ-018 busy  output  1  FSM is in MDU_WAIT.

Function
REQ-019 FSM states: RUN, MDU_WAIT; 4-bit down-counter wait_cnt.
REQ-020 Default outputs (RUN, no event): pc_write=1, ifid_write=1, idex_write=1, ifid_flush=0, idex_bubble=0, mdu_done=0.
REQ-021 Priority in RUN: mdu_start > br_taken > load-use > jump_id; only the highest active event acts.
REQ-022 RUN with mdu_start: pc_write=ifid_write=idex_write=0 in the same cycle; next state MDU_WAIT; wait_cnt loaded with MDU_LAT-2.
REQ-023 MDU_WAIT: pc_write=ifid_write=idex_write=0, busy=1; wait_cnt decrements each cycle.
REQ-024 MDU_WAIT with wait_cnt==0: mdu_done=1; next state RUN; total stall is exactly MDU_LAT cycles including the start cycle.
REQ-025 br_taken, jump_id, mdu_start and load-use are ignored in MDU_WAIT.
REQ-026 Load-use hazard = idex_mem_read && idex_dst!=0 && (idex_dst==id_rs || (id_uses_rt && idex_dst==id_rt)).
REQ-027 Load-use in RUN: pc_write=0, ifid_write=0, idex_bubble=1, idex_write=1; exactly one bubble, with no state change.
REQ-028 br_taken in RUN: ifid_flush=1, idex_bubble=1, pc_write=1; overrides a simultaneous load-use or jump.
REQ-029 jump_id in RUN: ifid_flush=1 only; all write enables remain 1.
REQ-030 Outputs are combinational from state, wait_cnt and inputs; state and wait_cnt are the only registers.

Reset
REQ-031 rst=1 at a clock edge: state=RUN, wait_cnt=0; stats counters clear to 0.
REQ-032 While rst=1, outputs hold the defaults of REQ-020 and busy=0.
REQ-033 Reset during MDU_WAIT aborts the stall with no mdu_done pulse.

Configuration
REQ-034 Macro HAZARD_STATS_EN defined: adds output stall_cnt [31:0] and output flush_cnt [15:0].
REQ-035 With HAZARD_STATS_EN: stall_cnt increments on each cycle with pc_write=0, and flush_cnt increments on each cycle with ifid_flush=1; both saturate at all-ones.
REQ-036 Without HAZARD_STATS_EN: both ports and their counters are absent; all other behaviour is identical.

Structure
REQ-037 Package pipe_ctrl_pkg holds: the state enum (RUN, MDU_WAIT), the constant MDU_LAT_DEF=4, and REG_ZERO=5'd0.
REQ-038 Sub-module hazard_detect is the combinational load-use comparator of REQ-026; pipe_hazard_ctrl instantiates it once.

Verification
REQ-039 idex_mem_read=1, idex_dst=8, id_rs=8 -> one cycle: pc_write=0, ifid_write=0, idex_bubble=1.
REQ-040 Same as REQ-039 with idex_dst=0 -> no stall; all enables 1.
REQ-041 mdu_start=1 with MDU_LAT=4 -> pc_write=0 for exactly 4 cycles; mdu_done on the 4th; busy high on cycles 2-4.
REQ-042 br_taken=1 together with a load-use match -> ifid_flush=1, idex_bubble=1, pc_write=1.
REQ-043 rst=1 on the 2nd MDU_WAIT cycle -> next cycle state RUN, pc_write=1, no mdu_done.
REQ-044 HAZARD_STATS_EN, 3 load-use stalls and 2 taken branches -> stall_cnt=3, flush_cnt=2.
